// File: rtl/stack_test_pkg.sv
// stack_test_pkg: shared definitions for the 3D-stack self-test controller.
//   - frame tags and the default sync word
//   - packed frame layout: [31:30] tag, [29:26] power, [25:21] field_a,
//     [20:16] field_b, [15:0] sync
//   - controller FSM state encoding
//   - frame builder and lowest-passing-power priority encoder
package stack_test_pkg;

   localparam logic [1:0]  TAG_ENUM          = 2'b10;
   localparam logic [1:0]  TAG_SWEEP         = 2'b01;
   localparam logic [1:0]  TAG_CFG           = 2'b00;
   localparam logic [1:0]  TAG_RESP          = 2'b11;
   localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hBEAF;

   // Field order fixes the bit positions: tag lands in [31:30], sync in [15:0].
   typedef struct packed {
      logic [1:0]  tag;
      logic [3:0]  power;
      logic [4:0]  field_a;
      logic [4:0]  field_b;
      logic [15:0] sync;
   } frame_t;

   typedef enum logic [3:0] {
      StIdle,
      StEnumTx,
      StEnumRx,
      StSweepTx,
      StSweepRx,
      StCfgTx,
      StCfgRx,
      StDone,
      StFail
   } state_e;

   function automatic frame_t mk_frame(input logic [1:0]  tag,
                                       input logic [3:0]  power,
                                       input logic [4:0]  field_a,
                                       input logic [4:0]  field_b,
                                       input logic [15:0] sync);
      frame_t f;
      f.tag     = tag;
      f.power   = power;
      f.field_a = field_a;
      f.field_b = field_b;
      f.sync    = sync;
      return f;
   endfunction

   // Lowest set bit among [15:1]; 0 means no power level passed.
   function automatic logic [3:0] lowest_pass(input logic [15:0] map);
      logic [3:0] sel;
      sel = 4'd0;
      for (int i = 15; i >= 1; i--) begin
         if (map[i]) sel = 4'(i);
      end
      return sel;
   endfunction

endpackage

// File: rtl/stack_rx_timer.sv
// stack_rx_timer: response timeout and per-request retry counter.
//   clk, rst_n    clock, async active-low reset
//   run_i         controller is waiting for a response; timer is held at 0 otherwise
//   retry_inc_i   a timeout is being turned into a resend
//   retry_clr_i   a response was accepted or a new sequence starts
//   expire_o      TIMEOUT cycles have elapsed in the current wait
//   give_up_o     RETRIES resends already spent on this request
module stack_rx_timer
   import stack_test_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned RETRIES = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run_i,
   input  logic retry_inc_i,
   input  logic retry_clr_i,
   output logic expire_o,
   output logic give_up_o
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned RW = $clog2(RETRIES + 1);
   localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);
   localparam logic [RW-1:0] RetryMax  = RW'(RETRIES);

   logic [TW-1:0] timer_q, timer_d;
   logic [RW-1:0] retry_q, retry_d;

   // Timer value k means the wait has lasted k+1 cycles including this one.
   assign expire_o  = run_i && (timer_q == TimerLast);
   assign give_up_o = (retry_q == RetryMax);

   always_comb begin
      timer_d = '0;
      if (run_i && !expire_o) timer_d = timer_q + 1'b1;
   end

   always_comb begin
      retry_d = retry_q;
      if (retry_clr_i) begin
         retry_d = '0;
      end else if (retry_inc_i && !give_up_o) begin
         retry_d = retry_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q <= '0;
         retry_q <= '0;
      end else begin
         timer_q <= timer_d;
         retry_q <= retry_d;
      end
   end

endmodule

// File: rtl/stack_sort_ctrl.sv
// stack_sort_ctrl: bottom-layer master of the 3D-stack self-test chain.
// Enumerates the layers, sweeps power 1..15, records levels that every layer
// passes and broadcasts the lowest passing level.
//   clk, rst_n     clock, async active-low reset
//   start_i        1-cycle pulse, starts a sequence when not busy
//   data_in_i      response frame, qualified by rx_valid_i
//   data_out_o     request frame, qualified by tx_valid_o, accepted with tx_ready_i
//   busy_o         sequence in progress
//   done_o/fail_o  sticky result until the next start
//   layer_count_o  enumerated layer count
//   power_sel_o    chosen power level (0 = none)
//   pass_map_o     bit p set when all layers passed at power p
module stack_sort_ctrl
   import stack_test_pkg::*;
#(
   parameter int unsigned MAX_LAYERS = 8,
   parameter int unsigned TIMEOUT    = 64,
   parameter int unsigned RETRIES    = 3,
   parameter logic [15:0] SYNC_WORD  = SYNC_WORD_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic [31:0] data_in_i,
   input  logic        rx_valid_i,
   output logic [31:0] data_out_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        fail_o,
   output logic [4:0]  layer_count_o,
   output logic [3:0]  power_sel_o,
   output logic [15:0] pass_map_o
);

   localparam logic [4:0] MaxLayersW = 5'(MAX_LAYERS);

   state_e      state_q;
   logic [3:0]  p_q;
   logic [4:0]  layer_count_q;
   logic [3:0]  power_sel_q;
   logic [15:0] pass_map_q;
   frame_t      data_out_q;
   logic        tx_valid_q;

   frame_t      rx_frame;
   logic        in_rx, rx_ok, accept, idle_like, start_ok;
   logic        expire, give_up, retry_inc;
   logic        sweep_pass;
   logic [15:0] pass_map_upd;
   logic [3:0]  lowest;
   logic        unused_field_a;

   assign rx_frame       = frame_t'(data_in_i);
   assign unused_field_a = ^rx_frame.field_a;

   assign in_rx     = state_q inside {StEnumRx, StSweepRx, StCfgRx};
   assign idle_like = state_q inside {StIdle, StDone, StFail};
   assign rx_ok     = rx_valid_i && (rx_frame.tag == TAG_RESP) && (rx_frame.sync == SYNC_WORD);
   assign accept    = in_rx && rx_ok;
   assign start_ok  = start_i && idle_like;
   // A frame arriving on the expiry cycle wins over the timeout.
   assign retry_inc = in_rx && !rx_ok && expire && !give_up;

   // Current sweep result is folded in so the choice sees power 15 as well.
   assign sweep_pass   = (rx_frame.field_b == layer_count_q);
   assign pass_map_upd = pass_map_q | (sweep_pass ? (16'd1 << p_q) : 16'd0);
   assign lowest       = lowest_pass(pass_map_upd);

   stack_rx_timer #(
      .TIMEOUT (TIMEOUT),
      .RETRIES (RETRIES)
   ) u_rx_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .run_i       (in_rx),
      .retry_inc_i (retry_inc),
      .retry_clr_i (accept || start_ok),
      .expire_o    (expire),
      .give_up_o   (give_up)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         p_q           <= 4'd0;
         layer_count_q <= 5'd0;
         power_sel_q   <= 4'd0;
         pass_map_q    <= 16'd0;
         data_out_q    <= '0;
         tx_valid_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StDone, StFail: begin
               if (start_i) begin
                  p_q           <= 4'd1;
                  layer_count_q <= 5'd0;
                  power_sel_q   <= 4'd0;
                  pass_map_q    <= 16'd0;
                  data_out_q    <= mk_frame(TAG_ENUM, 4'd1, 5'd0, 5'd1, SYNC_WORD);
                  tx_valid_q    <= 1'b1;
                  state_q       <= StEnumTx;
               end
            end

            // Request held stable until accepted; no timeout while transmitting.
            StEnumTx: begin
               if (tx_valid_q && tx_ready_i) begin
                  tx_valid_q <= 1'b0;
                  state_q    <= StEnumRx;
               end
            end

            StSweepTx: begin
               if (tx_valid_q && tx_ready_i) begin
                  tx_valid_q <= 1'b0;
                  state_q    <= StSweepRx;
               end
            end

            StCfgTx: begin
               if (tx_valid_q && tx_ready_i) begin
                  tx_valid_q <= 1'b0;
                  state_q    <= StCfgRx;
               end
            end

            StEnumRx: begin
               if (rx_ok) begin
                  layer_count_q <= rx_frame.field_b;
                  if (rx_frame.field_b == 5'd0 || rx_frame.field_b > MaxLayersW) begin
                     state_q <= StFail;
                  end else begin
                     data_out_q <= mk_frame(TAG_SWEEP, p_q, 5'd0, rx_frame.field_b, SYNC_WORD);
                     tx_valid_q <= 1'b1;
                     state_q    <= StSweepTx;
                  end
               end else if (expire) begin
                  if (give_up) begin
                     state_q <= StFail;
                  end else begin
                     tx_valid_q <= 1'b1;
                     state_q    <= StEnumTx;
                  end
               end
            end

            StSweepRx: begin
               if (rx_ok) begin
                  pass_map_q <= pass_map_upd;
                  if (p_q == 4'd15) begin
                     power_sel_q <= lowest;
                     if (lowest == 4'd0) begin
                        state_q <= StFail;
                     end else begin
                        data_out_q <= mk_frame(TAG_CFG, lowest, 5'd0, 5'd0, SYNC_WORD);
                        tx_valid_q <= 1'b1;
                        state_q    <= StCfgTx;
                     end
                  end else begin
                     p_q        <= p_q + 4'd1;
                     data_out_q <= mk_frame(TAG_SWEEP, p_q + 4'd1, 5'd0, layer_count_q,
                                            SYNC_WORD);
                     tx_valid_q <= 1'b1;
                     state_q    <= StSweepTx;
                  end
               end else if (expire) begin
                  if (give_up) begin
                     state_q <= StFail;
                  end else begin
                     tx_valid_q <= 1'b1;
                     state_q    <= StSweepTx;
                  end
               end
            end

            StCfgRx: begin
               if (rx_ok) begin
                  state_q <= (rx_frame.power == power_sel_q) ? StDone : StFail;
               end else if (expire) begin
                  if (give_up) begin
                     state_q <= StFail;
                  end else begin
                     tx_valid_q <= 1'b1;
                     state_q    <= StCfgTx;
                  end
               end
            end

            default: begin
               tx_valid_q <= 1'b0;
               state_q    <= StIdle;
            end
         endcase
      end
   end

   assign data_out_o    = data_out_q;
   assign tx_valid_o    = tx_valid_q;
   assign busy_o        = !idle_like;
   assign done_o        = (state_q == StDone);
   assign fail_o        = (state_q == StFail);
   assign layer_count_o = layer_count_q;
   assign power_sel_o   = power_sel_q;
   assign pass_map_o    = pass_map_q;

endmodule

// File: tb/tb_stack_sort_ctrl.sv
// tb_stack_sort_ctrl: self-checking bench for stack_sort_ctrl.
// Expected request frames are queued when stimulus is applied and compared
// when the controller presents them; sweep results come from a vector table.
module tb_stack_sort_ctrl;

   localparam logic [1:0]  T_ENUM  = 2'b10;
   localparam logic [1:0]  T_SWEEP = 2'b01;
   localparam logic [1:0]  T_CFG   = 2'b00;
   localparam logic [1:0]  T_RESP  = 2'b11;
   localparam logic [15:0] SYNC    = 16'hBEAF;
   localparam int          TMO     = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] data_in = 32'd0;
   logic        rx_valid = 1'b0;
   logic        tx_ready = 1'b1;
   logic [31:0] data_out;
   logic        tx_valid, busy, done, fail;
   logic [4:0]  layer_count;
   logic [3:0]  power_sel;
   logic [15:0] pass_map;

   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [3:0]  p;
      logic [4:0]  fb;
      logic [15:0] exp_map;
   } vec_t;
   vec_t vec[30];

   stack_sort_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start),
      .data_in_i     (data_in),
      .rx_valid_i    (rx_valid),
      .data_out_o    (data_out),
      .tx_valid_o    (tx_valid),
      .tx_ready_i    (tx_ready),
      .busy_o        (busy),
      .done_o        (done),
      .fail_o        (fail),
      .layer_count_o (layer_count),
      .power_sel_o   (power_sel),
      .pass_map_o    (pass_map)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] fr(input logic [1:0] t, input logic [3:0] pw,
                                      input logic [4:0] fb, input logic [15:0] s);
      return {t, pw, 5'd0, fb, s};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Waits (bounded) for a request, compares it with the queue head, then lets
   // the handshake edge pass. waited = cycles spent before tx_valid showed up.
   task automatic expect_req(input string name, output int waited);
      logic        seen;
      logic [31:0] exp;
      seen   = 1'b0;
      waited = 0;
      while (!seen && waited < 300) begin
         if (tx_valid) seen = 1'b1;
         else begin
            step();
            waited++;
         end
      end
      check({name, "_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: unexpected request %h", name, data_out);
         end else begin
            exp = exp_q.pop_front();
            check(name, data_out, exp);
         end
         step();
      end
   endtask

   task automatic respond(input logic [1:0] t, input logic [3:0] pw, input logic [4:0] fb,
                          input logic [15:0] s);
      data_in  = fr(t, pw, fb, s);
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
      data_in  = 32'd0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic enum_seq(input logic [4:0] fb);
      int w;
      exp_q.push_back(fr(T_ENUM, 4'd1, 5'd1, SYNC));
      pulse_start();
      expect_req("enum_req", w);
      respond(T_RESP, 4'd0, fb, SYNC);
      check("enum_layer_count", 32'(layer_count), 32'(fb));
   endtask

   task automatic run_sweep(input int lo, input logic [4:0] lc);
      int w;
      exp_q.push_back(fr(T_SWEEP, 4'd1, lc, SYNC));
      for (int i = lo; i < lo + 15; i++) begin
         expect_req("sweep_req", w);
         respond(T_RESP, vec[i].p, vec[i].fb, SYNC);
         check("sweep_pass_map", 32'(pass_map), 32'(vec[i].exp_map));
         if (vec[i].p != 4'd15) exp_q.push_back(fr(T_SWEEP, vec[i].p + 4'd1, lc, SYNC));
      end
   endtask

   initial begin
      int          w;
      int          stable;
      logic [15:0] m;

      // Table: rows 0..14 pass for p>=6 (4 layers), rows 15..29 never pass.
      m = 16'd0;
      for (int i = 0; i < 15; i++) begin
         vec[i].p  = 4'(i + 1);
         vec[i].fb = (i + 1 >= 6) ? 5'd4 : 5'd3;
         if (i + 1 >= 6) m[i + 1] = 1'b1;
         vec[i].exp_map = m;
         vec[15 + i].p       = 4'(i + 1);
         vec[15 + i].fb      = 5'd3;
         vec[15 + i].exp_map = 16'd0;
      end

      // Reset values
      repeat (3) step();
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_data_out", data_out, 32'd0);
      check("rst_flags", 32'({busy, done, fail}), 32'd0);
      check("rst_regs", 32'({layer_count, power_sel, pass_map}), 32'd0);
      rst_n = 1'b1;
      step();
      check("idle_busy", 32'(busy), 32'd0);

      // 1: full passing sequence
      enum_seq(5'd4);
      check("run_busy", 32'(busy), 32'd1);
      run_sweep(0, 5'd4);
      check("choose_power", 32'(power_sel), 32'd6);
      exp_q.push_back(fr(T_CFG, 4'd6, 5'd0, SYNC));
      expect_req("cfg_req", w);
      respond(T_RESP, 4'd6, 5'd0, SYNC);
      check("t1_done", 32'({done, fail, busy}), 32'b100);
      check("t1_pass_map", 32'(pass_map), 32'h0000_FFC0);
      check("t1_power_sel", 32'(power_sel), 32'd6);
      check("t1_layer_count", 32'(layer_count), 32'd4);

      // 2: illegal layer counts
      enum_seq(5'd0);
      check("t2_zero_fail", 32'({done, fail, busy}), 32'b010);
      enum_seq(5'd9);
      check("t2_nine_fail", 32'({done, fail, busy}), 32'b010);

      // 3: sweep p=3 never answered
      enum_seq(5'd2);
      exp_q.push_back(fr(T_SWEEP, 4'd1, 5'd2, SYNC));
      for (int p = 1; p <= 2; p++) begin
         expect_req("t3_sweep_req", w);
         respond(T_RESP, 4'(p), 5'd2, SYNC);
         exp_q.push_back(fr(T_SWEEP, 4'(p + 1), 5'd2, SYNC));
      end
      expect_req("t3_p3_req", w);
      for (int r = 0; r < 3; r++) begin
         exp_q.push_back(fr(T_SWEEP, 4'd3, 5'd2, SYNC));
         expect_req("t3_resend", w);
         check("t3_resend_delay", 32'(w), 32'(TMO));
      end
      w = 0;
      while (!fail && w < 300) begin
         step();
         w++;
      end
      check("t3_fail_delay", 32'(w), 32'(TMO));
      check("t3_fail", 32'({done, fail, busy, tx_valid}), 32'b0100);

      // 4: tx_ready withheld during ENUM_TX
      exp_q.push_back(fr(T_ENUM, 4'd1, 5'd1, SYNC));
      tx_ready = 1'b0;
      pulse_start();
      stable = 0;
      for (int i = 0; i < 20; i++) begin
         if (tx_valid && data_out == fr(T_ENUM, 4'd1, 5'd1, SYNC) && busy && !fail) stable++;
         step();
      end
      check("t4_hold_cycles", 32'(stable), 32'd20);
      tx_ready = 1'b1;
      expect_req("t4_enum_req", w);
      check("t4_no_wait", 32'(w), 32'd0);
      respond(T_RESP, 4'd0, 5'd3, SYNC);

      // 5: bad frames ignored, valid frame on the expiry cycle accepted
      exp_q.push_back(fr(T_SWEEP, 4'd1, 5'd3, SYNC));
      expect_req("t5_sweep1", w);
      respond(T_RESP, 4'd1, 5'd3, 16'hDEAD);
      check("t5_bad_sync", 32'({pass_map, tx_valid}), 32'd0);
      respond(T_ENUM, 4'd1, 5'd3, SYNC);
      check("t5_bad_tag", 32'({pass_map, tx_valid, busy}), 32'd1);
      repeat (TMO - 3) step();
      respond(T_RESP, 4'd1, 5'd3, SYNC);
      check("t5_expiry_accept", 32'(pass_map), 32'h0000_0002);
      // rx_valid outside an RX state is ignored
      tx_ready = 1'b0;
      respond(T_RESP, 4'd2, 5'd3, SYNC);
      check("t5_tx_rx_ignored", 32'({pass_map, tx_valid}), 32'h0000_0005);
      tx_ready = 1'b1;
      exp_q.push_back(fr(T_SWEEP, 4'd2, 5'd3, SYNC));
      expect_req("t5_sweep2", w);
      check("t5_no_resend", 32'(w), 32'd0);
      pulse_start();
      check("t5_start_busy", 32'({busy, layer_count, pass_map, tx_valid}),
            32'({1'b1, 5'd3, 16'h0002, 1'b0}));
      respond(T_RESP, 4'd2, 5'd3, SYNC);
      check("t5_p2_pass", 32'({pass_map, tx_valid}), 32'({16'h0006, 1'b1}));

      // 6a: reset mid-sweep drops everything
      rst_n = 1'b0;
      #1;
      check("t6_rst_tx", 32'({tx_valid, busy}), 32'd0);
      check("t6_rst_data", data_out, 32'd0);
      check("t6_rst_regs", 32'({layer_count, power_sel, pass_map}), 32'd0);
      step();
      rst_n = 1'b1;
      exp_q.delete();
      step();

      // 6b: no level passes
      enum_seq(5'd4);
      run_sweep(15, 5'd4);
      check("t6_fail", 32'({done, fail, busy, tx_valid}), 32'b0100);
      check("t6_power_sel", 32'(power_sel), 32'd0);
      check("t6_pass_map", 32'(pass_map), 32'd0);
      check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
